// File: rtl/pipeline_hazard_scheduler.sv
// Hazard/stall scheduler for a 5-stage pipeline: tracks pending writebacks in EXE and MEM,
// and arbitrates between RAW stalls, taken-branch flushes and data-memory wait states.
module pipeline_hazard_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       src1_used,
    input  logic       src2_used,
    input  logic [3:0] id_dest,
    input  logic       id_wb_en,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       freeze,
    output logic       bubble,
    output logic       flush,
    output logic       mem_hold,
    output logic [7:0] wait_cnt
);
    localparam int EXE = 0;
    localparam int MEM = 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Scoreboard entries, index EXE = younger, MEM = older.
    logic [1:0] v_q, v_d;
    logic [1:0] memop_q, memop_d;
    logic [3:0] dest_q [2];
    logic [3:0] dest_d [2];

    logic [1:0] match;
    logic       hazard;
    logic       hold_c;
    logic       flush_c;
    logic       bubble_c;
    logic       freeze_c;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            assign match[gi] = v_q[gi] &
                               ((src1_used & (dest_q[gi] == src1)) |
                                (src2_used & (dest_q[gi] == src2)));
        end
    endgenerate

    // A pending memory access outranks everything; a taken branch outranks a RAW stall.
    always_comb begin
        hazard   = id_valid & (|match);
        hold_c   = memop_q[MEM] & ~mem_ready;
        flush_c  = branch_taken & ~hold_c;
        bubble_c = (hazard | flush_c) & ~hold_c;
        freeze_c = hold_c | (hazard & ~flush_c);
    end

    always_comb begin
        v_d     = v_q;
        memop_d = memop_q;
        dest_d  = dest_q;
        if (!hold_c) begin
            v_d[MEM]     = v_q[EXE];
            memop_d[MEM] = memop_q[EXE];
            dest_d[MEM]  = dest_q[EXE];
            // Stores keep memop set even though they never write back.
            v_d[EXE]     = id_valid & id_wb_en & ~bubble_c;
            memop_d[EXE] = id_valid & (id_mem_read | id_mem_write) & ~bubble_c;
            dest_d[EXE]  = id_dest;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (memop_q[MEM] & ~mem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            v_q        <= 2'b00;
            memop_q    <= 2'b00;
            dest_q[0]  <= 4'd0;
            dest_q[1]  <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            v_q        <= v_d;
            memop_q    <= memop_d;
            dest_q[0]  <= dest_d[0];
            dest_q[1]  <= dest_d[1];
        end
    end

    // Gate with rst so a branch_taken seen during reset cannot leak out as a flush.
    assign mem_hold = hold_c & ~rst;
    assign flush    = flush_c & ~rst;
    assign bubble   = bubble_c & ~rst;
    assign freeze   = freeze_c & ~rst;
    assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Scoreboard bench for pipeline_hazard_scheduler: directed scenarios plus random traffic,
// checked against an in-flight-instruction model of the hazard rules.
module tb_pipeline_hazard_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] src1 = 4'd0;
    logic [3:0] src2 = 4'd0;
    logic       src1_used = 1'b0;
    logic       src2_used = 1'b0;
    logic [3:0] id_dest = 4'd0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       id_mem_write = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b1;
    logic       freeze;
    logic       bubble;
    logic       flush;
    logic       mem_hold;
    logic [7:0] wait_cnt;

    pipeline_hazard_scheduler dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src1_used(src1_used), .src2_used(src2_used), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .freeze(freeze),
        .bubble(bubble), .flush(flush), .mem_hold(mem_hold), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [3:0] src1;
        bit [3:0] src2;
        bit       s1u;
        bit       s2u;
        bit [3:0] dest;
        bit       wb;
        bit       mr;
        bit       mw;
        bit       br;
        bit       ready;
        bit       rst;
    } stim_t;

    typedef struct {
        int txn;
        bit rst;
        bit freeze;
        bit bubble;
        bit flush;
        bit hold;
        int wait_cnt;
    } exp_t;

    typedef struct {
        bit       v;
        bit [3:0] dest;
        bit       memop;
    } inflight_t;

    exp_t      exp_q[$];
    exp_t      mon_e;
    inflight_t pipe[2];     // [0] = youngest in-flight (EXE), [1] = older (MEM)
    int        hold_run = 0; // length of the current/last run of stalled-memory cycles
    bit        prev_hold = 0;
    int        checks = 0;
    int        errors = 0;
    int        txn = 0;
    bit        running = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic stim_t mk(input bit valid, input bit [3:0] s1, input bit s1u,
                                 input bit [3:0] dest, input bit wb, input bit mr,
                                 input bit br, input bit ready);
        stim_t s;
        s.valid = valid; s.src1 = s1; s.s1u = s1u; s.src2 = 4'd0; s.s2u = 1'b0;
        s.dest = dest; s.wb = wb; s.mr = mr; s.mw = 1'b0; s.br = br;
        s.ready = ready; s.rst = 1'b0;
        return s;
    endfunction

    function automatic bit [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    // Apply one cycle of stimulus, predict this cycle's outputs, then advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit   hazard, hold, fl, bb, fz;
        @(posedge clk);
        #1;
        id_valid = s.valid; src1 = s.src1; src2 = s.src2;
        src1_used = s.s1u; src2_used = s.s2u; id_dest = s.dest;
        id_wb_en = s.wb; id_mem_read = s.mr; id_mem_write = s.mw;
        branch_taken = s.br; mem_ready = s.ready; rst = s.rst;

        e.txn = txn;
        e.rst = s.rst;
        if (s.rst) begin
            pipe[0] = '{0, 0, 0};
            pipe[1] = '{0, 0, 0};
            hold_run = 0;
            prev_hold = 0;
            e.freeze = 0; e.bubble = 0; e.flush = 0; e.hold = 0; e.wait_cnt = 0;
        end else begin
            hazard = 0;
            for (int i = 0; i < 2; i++) begin
                if (s.valid && pipe[i].v &&
                    ((s.s1u && pipe[i].dest == s.src1) || (s.s2u && pipe[i].dest == s.src2)))
                    hazard = 1;
            end
            hold = pipe[1].memop && !s.ready;
            fl   = s.br && !hold;
            bb   = (hazard || fl) && !hold;
            fz   = hold || (hazard && !fl);
            e.freeze = fz; e.bubble = bb; e.flush = fl; e.hold = hold;
            e.wait_cnt = hold_run;
            if (hold)
                hold_run = prev_hold ? ((hold_run < 255) ? hold_run + 1 : 255) : 1;
            prev_hold = hold;
            if (!hold) begin
                pipe[1] = pipe[0];
                pipe[0].v = s.valid && s.wb && !bb;
                pipe[0].dest = s.dest;
                pipe[0].memop = s.valid && (s.mr || s.mw) && !bb;
            end
        end
        exp_q.push_back(e);
        running = 1;
        txn++;
    endtask

    task automatic do_reset();
        stim_t s;
        s = mk(0, 0, 0, 0, 0, 0, 0, 1);
        s.rst = 1;
        step(s);
        step(s);
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("freeze", int'(freeze), int'(mon_e.freeze));
                chk("bubble", int'(bubble), int'(mon_e.bubble));
                chk("flush", int'(flush), int'(mon_e.flush));
                chk("mem_hold", int'(mem_hold), int'(mon_e.hold));
                chk("wait_cnt", int'(wait_cnt), mon_e.wait_cnt);
                $display("txn %0d rst=%0b freeze=%0b bubble=%0b flush=%0b mem_hold=%0b wait_cnt=%0d",
                         mon_e.txn, mon_e.rst, freeze, bubble, flush, mem_hold, wait_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        stim_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 1);

        // RAW on an instruction in EXE, then MEM
        do_reset();
        step(mk(1, 0, 0, 3, 1, 0, 0, 1));
        s = mk(1, 3, 1, 5, 1, 0, 0, 1);
        step(s); #2; chk("raw_c1_freeze", int'(freeze), 1); chk("raw_c1_bubble", int'(bubble), 1);
        step(s); #2; chk("raw_c2_freeze", int'(freeze), 1); chk("raw_c2_bubble", int'(bubble), 1);
        step(s); #2; chk("raw_c3_freeze", int'(freeze), 0);

        // Load waits four cycles in MEM
        do_reset();
        step(mk(1, 0, 0, 7, 1, 1, 0, 1));
        step(nop);
        repeat (4) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0));
            #2; chk("wait_hold", int'(mem_hold), 1); chk("wait_freeze", int'(freeze), 1);
        end
        step(nop); #2; chk("wait_done_hold", int'(mem_hold), 0); chk("wait_cnt_4", int'(wait_cnt), 4);
        step(nop); #2; chk("wait_cnt_kept", int'(wait_cnt), 4);

        // Branch beats a data hazard
        do_reset();
        step(mk(1, 0, 0, 3, 1, 0, 0, 1));
        step(mk(1, 3, 1, 5, 1, 0, 1, 1)); #2;
        chk("brh_flush", int'(flush), 1); chk("brh_bubble", int'(bubble), 1);
        chk("brh_freeze", int'(freeze), 0);

        // Branch during a memory hold is deferred
        do_reset();
        step(mk(1, 0, 0, 2, 1, 1, 0, 1));
        step(nop);
        repeat (2) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 0)); #2; chk("brhold_flush", int'(flush), 0);
        end
        step(mk(0, 0, 0, 0, 0, 0, 1, 1)); #2; chk("brhold_release_flush", int'(flush), 1);

        // Saturation
        do_reset();
        step(mk(1, 0, 0, 9, 1, 1, 0, 1));
        step(nop);
        repeat (300) step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(nop); #2; chk("wait_cnt_sat", int'(wait_cnt), 255);

        // Reset in the middle of a WAIT
        do_reset();
        step(mk(1, 0, 0, 4, 1, 1, 0, 1));
        step(nop);
        repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        s = mk(1, 4, 1, 6, 1, 1, 1, 0);
        s.rst = 1;
        step(s); #2;
        chk("rst_freeze", int'(freeze), 0); chk("rst_bubble", int'(bubble), 0);
        chk("rst_flush", int'(flush), 0); chk("rst_hold", int'(mem_hold), 0);
        chk("rst_wait_cnt", int'(wait_cnt), 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); #2;
        chk("post_rst_freeze", int'(freeze), 0); chk("post_rst_hold", int'(mem_hold), 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            s.valid = ($urandom_range(0, 9) < 8);
            s.src1 = pick_reg(); s.src2 = pick_reg();
            s.s1u = $urandom_range(0, 1); s.s2u = $urandom_range(0, 1);
            s.dest = pick_reg(); s.wb = ($urandom_range(0, 3) != 0);
            s.mr = ($urandom_range(0, 3) == 0); s.mw = ($urandom_range(0, 5) == 0);
            s.br = ($urandom_range(0, 7) == 0); s.ready = ($urandom_range(0, 9) < 6);
            s.rst = ($urandom_range(0, 99) == 0);
            step(s);
        end

        @(negedge clk);
        #1;
        running = 0;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_scheduler.md
PIPELINE_HAZARD_SCHEDULER -- requirements
Module: pipeline_hazard_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port id_valid, input, 1 bit: ID holds a real instruction whose condition check passed.
REQ-004 SHALL have ports src1 and src2, input, 4 bits each: ID source register numbers.
REQ-005 SHALL have ports src1_used and src2_used, input, 1 bit each: qualifies src1 and src2 for the hazard check.
REQ-006 SHALL have port id_dest, input, 4 bits: ID destination register.
REQ-007 SHALL have port id_wb_en, input, 1 bit: ID instruction writes back.
REQ-008 SHALL have ports id_mem_read and id_mem_write, input, 1 bit each: ID instruction accesses memory.
REQ-009 SHALL have port branch_taken, input, 1 bit: instruction currently in EXE is a taken branch.
REQ-010 SHALL have port mem_ready, input, 1 bit: data memory completes the current access this cycle.
REQ-011 SHALL have port freeze, output, 1 bit: hold PC and IF/ID register.
REQ-012 SHALL have port bubble, output, 1 bit: zero ID control outputs into ID/EXE.
REQ-013 SHALL have port flush, output, 1 bit: clear IF/ID register.
REQ-014 SHALL have port mem_hold, output, 1 bit: hold ID/EXE, EXE/MEM and MEM/WB registers.
REQ-015 SHALL have port wait_cnt, output, 8 bits: number of cycles spent in the current or last WAIT.

Function
REQ-016 SHALL keep two scoreboard entries, EXE and MEM, each holding {v, dest[3:0], memop}; v means a pending writeback.
REQ-017 SHALL compute hazard = id_valid & any of: (src1_used & x.v & x.dest==src1) or (src2_used & x.v & x.dest==src2), for x in {EXE, MEM}.
REQ-018 SHALL treat WB-stage writes as visible in ID the same cycle, so WB is not tracked.
REQ-019 SHALL compute mem_hold = MEM.memop & ~mem_ready, combinationally.
REQ-020 SHALL compute flush = branch_taken & ~mem_hold.
REQ-021 SHALL compute bubble = (hazard | flush) & ~mem_hold.
REQ-022 SHALL compute freeze = mem_hold | (hazard & ~flush); branch_taken has priority over a data hazard.
REQ-023 SHALL, when mem_hold=1, hold both scoreboard entries unchanged.
REQ-024 SHALL, when mem_hold=0, load MEM <= EXE.
REQ-025 SHALL, when mem_hold=0, load EXE <= {id_valid & id_wb_en & ~bubble, id_dest, id_valid & (id_mem_read|id_mem_write) & ~bubble}.
REQ-026 SHALL store memop for stores even when v=0.
REQ-027 SHALL implement FSM state IDLE: go to WAIT when MEM.memop & ~mem_ready, clearing wait_cnt to 1 on entry; otherwise stay in IDLE.
REQ-028 SHALL implement FSM state WAIT: increment wait_cnt each cycle while mem_ready=0, saturating at 255; go to IDLE on mem_ready=1, retaining wait_cnt.
REQ-029 SHALL treat mem_ready=1 in the same cycle a memop reaches MEM as a zero-wait access: no WAIT entry, mem_hold=0, wait_cnt unchanged.
REQ-030 SHALL resolve simultaneous branch_taken and mem_hold in favour of mem_hold; the flush is deferred until the hold clears.
REQ-031 SHALL allow a dest match on r15 like any other register, with no special casing.

Reset
REQ-032 SHALL, while rst=1, force the FSM to IDLE, clear both entries to 0, and clear wait_cnt to 0, asynchronously.
REQ-033 SHALL, while rst=1, drive freeze, bubble, flush and mem_hold to 0.
REQ-034 SHALL, on rst asserted mid-WAIT, abandon the access; the first cycle after release sees no hazard and no hold.

Verification
REQ-035 SHALL be verified by a RAW on EXE: cycle 0 issues dest=3, wb_en=1; cycle 1 ID src1=3 -> freeze=1 and bubble=1 in cycles 1 and 2, and freeze=0 in cycle 3.
REQ-036 SHALL be verified by memory wait: a load reaches MEM with mem_ready low for 4 cycles -> mem_hold=1 and freeze=1 for 4 cycles, wait_cnt=4 afterwards, FSM back in IDLE.
REQ-037 SHALL be verified by branch versus hazard: branch_taken=1 and hazard=1 in the same cycle -> flush=1, bubble=1, freeze=0.
REQ-038 SHALL be verified by branch during a hold: branch_taken=1 while mem_hold=1 -> flush=0 until mem_ready=1, then flush=1 that cycle.
REQ-039 SHALL be verified by saturation: mem_ready low for 300 cycles -> wait_cnt=255.
REQ-040 SHALL be verified by reset mid-WAIT: rst pulsed at wait cycle 2 -> all outputs 0 immediately, and no freeze after release with id_valid=0.
